// File: rtl/key_insn_pkg.sv
// ============================================================================
// Module      : key_insn_pkg
// Description : Shared constants, arbiter state encoding and helpers for the
//               key instruction arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_insn_pkg;

    localparam logic [31:0] KEY_INSN_RIGHT = 32'h5800_0001;
    localparam logic [31:0] KEY_INSN_FIRE  = 32'h5800_0002;
    localparam logic [31:0] KEY_INSN_LEFT  = 32'h5800_0003;
    localparam logic [31:0] KEY_INSN_NONE  = 32'h0000_0000;

    localparam logic [1:0] KEY_IDX_RIGHT = 2'd0;
    localparam logic [1:0] KEY_IDX_FIRE  = 2'd1;
    localparam logic [1:0] KEY_IDX_LEFT  = 2'd2;
    localparam logic [1:0] GRANT_NONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        ISSUE      = 2'd2
    } arb_state_e;

    function automatic logic [31:0] key_insn_word(input logic [1:0] idx);
        logic [31:0] word;
        case (idx)
            KEY_IDX_RIGHT: word = KEY_INSN_RIGHT;
            KEY_IDX_FIRE:  word = KEY_INSN_FIRE;
            KEY_IDX_LEFT:  word = KEY_INSN_LEFT;
            default:       word = KEY_INSN_NONE;
        endcase
        return word;
    endfunction

    // Round-robin search over indices 0..2 starting just after the last grant.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = GRANT_NONE;
        idx  = (last >= KEY_IDX_LEFT) ? KEY_IDX_RIGHT : last + 2'd1;
        for (int i = 0; i < 3; i++) begin
            if ((pick == GRANT_NONE) && req[idx]) begin
                pick = idx;
            end
            idx = (idx == KEY_IDX_LEFT) ? KEY_IDX_RIGHT : idx + 2'd1;
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchroniser, counter debouncer and press-edge pulse
//               for one active-low push-button.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DB_W            = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press
);

    localparam logic [DB_W-1:0] c_cnt_last = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1_q;
    logic            r_sync2_q;
    logic            r_level_n_q;
    logic            r_level_n_d;
    logic [DB_W-1:0] r_cnt_q;
    logic [DB_W-1:0] r_cnt_d;
    logic            w_differ;
    logic            w_flip;

    always_comb begin
        w_differ    = (r_sync2_q != r_level_n_q);
        w_flip      = w_differ && (r_cnt_q == c_cnt_last);
        r_level_n_d = w_flip ? r_sync2_q : r_level_n_q;
        r_cnt_d     = (!w_differ || w_flip) ? '0 : r_cnt_q + DB_W'(1);
    end

    // Press pulse coincides with the edge that commits the new debounced level.
    assign press   = w_flip && !r_sync2_q;
    assign pressed = !r_level_n_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1_q   <= 1'b1;
            r_sync2_q   <= 1'b1;
            r_level_n_q <= 1'b1;
            r_cnt_q     <= '0;
        end else begin
            r_sync1_q   <= key_n;
            r_sync2_q   <= r_sync1_q;
            r_level_n_q <= r_level_n_d;
            r_cnt_q     <= r_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/key_insn_arbiter.sv
// ============================================================================
// Module      : key_insn_arbiter
// Description : Debounces three push-buttons, latches presses and issues one
//               key instruction per frame, round-robin, over valid/ack.
//               Optional auto-repeat of held keys: define KEY_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_insn_arbiter
    import key_insn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DB_W            = 5,
    parameter int ACK_TIMEOUT     = 1024,
    parameter int TO_W            = 11,
    parameter int REPEAT_FRAMES   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  key_n,
    input  logic        frame_tick,
    input  logic        insn_ack,
    output logic [31:0] insn_key,
    output logic        key_pressed,
    output logic [1:0]  grant,
    output logic [2:0]  pending
);

    localparam logic [TO_W-1:0] c_to_last = TO_W'(ACK_TIMEOUT - 1);

    logic [2:0]      w_level;
    logic [2:0]      w_press;
    logic [2:0]      w_repeat;
    logic [2:0]      w_clear;
    logic [1:0]      w_pick;

    arb_state_e      r_state_q;
    arb_state_e      r_state_d;
    logic [2:0]      r_pending_q;
    logic [2:0]      r_pending_d;
    logic [1:0]      r_grant_q;
    logic [1:0]      r_grant_d;
    logic [1:0]      r_last_q;
    logic [1:0]      r_last_d;
    logic [TO_W-1:0] r_tcnt_q;
    logic [TO_W-1:0] r_tcnt_d;

    for (genvar k = 0; k < 3; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DB_W            (DB_W)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .key_n   (key_n[k]),
            .pressed (w_level[k]),
            .press   (w_press[k])
        );
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int c_rep_w = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

    for (genvar k = 0; k < 3; k++) begin : g_repeat
        logic [c_rep_w-1:0] r_rep_q;
        logic [c_rep_w-1:0] r_rep_d;
        logic               w_wrap;

        assign w_wrap      = w_level[k] && frame_tick &&
                             (r_rep_q == c_rep_w'(REPEAT_FRAMES - 1));
        assign w_repeat[k] = w_wrap;

        always_comb begin
            r_rep_d = r_rep_q;
            if (!w_level[k] || w_wrap) begin
                r_rep_d = '0;
            end else if (frame_tick) begin
                r_rep_d = r_rep_q + c_rep_w'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_rep_q <= '0;
            end else begin
                r_rep_q <= r_rep_d;
            end
        end
    end
`else
    // Held level and repeat period only feed the auto-repeat counters.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{w_level, 32'(REPEAT_FRAMES)};
    assign w_repeat     = 3'b000;
`endif

    assign w_pick = rr_pick(r_pending_q, r_last_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= IDLE;
            r_pending_q <= 3'b000;
            r_grant_q   <= GRANT_NONE;
            r_last_q    <= KEY_IDX_LEFT;
            r_tcnt_q    <= '0;
        end else begin
            r_state_q   <= r_state_d;
            r_pending_q <= r_pending_d;
            r_grant_q   <= r_grant_d;
            r_last_q    <= r_last_d;
            r_tcnt_q    <= r_tcnt_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_grant_d = r_grant_q;
        r_last_d  = r_last_q;
        r_tcnt_d  = r_tcnt_q;
        w_clear   = 3'b000;
        case (r_state_q)
            IDLE: begin
                if (r_pending_q != 3'b000) begin
                    r_state_d = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (r_pending_q == 3'b000) begin
                    r_state_d = IDLE;
                end else if (frame_tick) begin
                    r_state_d = ISSUE;
                    r_grant_d = w_pick;
                    r_tcnt_d  = '0;
                end
            end
            ISSUE: begin
                if (insn_ack) begin
                    w_clear   = 3'b001 << r_grant_q;
                    r_last_d  = r_grant_q;
                    r_state_d = IDLE;
                end else if (r_tcnt_q == c_to_last) begin
                    // Unacknowledged request is abandoned but stays pending for a retry.
                    r_last_d  = r_grant_q;
                    r_state_d = IDLE;
                end else begin
                    r_tcnt_d  = r_tcnt_q + TO_W'(1);
                end
            end
            default: begin
                r_state_d = IDLE;
            end
        endcase
        r_pending_d = (r_pending_q & ~w_clear) | w_press | w_repeat;
    end

    always_comb begin
        key_pressed = (r_state_q == ISSUE);
        grant       = key_pressed ? r_grant_q : GRANT_NONE;
        insn_key    = key_pressed ? key_insn_word(r_grant_q) : KEY_INSN_NONE;
        pending     = r_pending_q;
    end

endmodule

`default_nettype wire

// File: doc/key_insn_arbiter.md
Name: key_insn_arbiter

Overview:
Sequences player button input into the game processor. It synchronises and debounces the three push-buttons (active-low), latches press requests, and arbitrates them round-robin. It issues at most one instruction word per video frame over a valid/ack handshake. It sits between the board KEY inputs and the processor's insn_key/key_pressed inputs, clocked by the processor clock.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required before a key's debounced level changes.
DB_W, 5, width of each debounce counter; must hold DEBOUNCE_CYCLES.
ACK_TIMEOUT, 1024, cycles insn_valid may stay unacknowledged before the request is dropped.
TO_W, 11, width of the timeout counter.
REPEAT_FRAMES, 8, frame_ticks between auto-repeats of a held key (used only with the optional feature).

Ports:
clk  in  1  processor clock; single clock domain.
reset  in  1  synchronous, active-high reset.
key_n  in  3  raw buttons, active-low, asynchronous: [2]=KEY3 left, [1]=KEY2 fire, [0]=KEY1 right.
frame_tick  in  1  one-cycle pulse per frame, already in the clk domain.
insn_ack  in  1  processor has consumed insn_key this cycle.
insn_key  out  32  instruction word for the granted key; 0 when idle.
key_pressed  out  1  valid strobe; level, equal to insn_valid.
grant  out  2  index of the key being issued (0 right, 1 fire, 2 left); 3 when idle.
pending  out  3  latched request flags, for debug.

Behaviour:
- Reset: all outputs are 0 except grant=3. Synchronisers are cleared to the released state (1). Debounced levels are released, counters 0, pending 0, last-grant pointer 2, FSM IDLE. Reset asserted mid-handshake drops key_pressed at the next edge; no ack is required.
- Input path: 2-FF synchroniser per key, then the debouncer. The counter increments while the synced value differs from the debounced level and clears when they match. When the counter reaches DEBOUNCE_CYCLES-1 and the next sample still differs, the debounced level flips and the counter clears. Latency from a stable raw edge to the debounced edge is DEBOUNCE_CYCLES+2 cycles.
- Press detect: a debounced released->pressed transition sets pending[k]. Further presses while pending[k]=1 are absorbed, with no queueing beyond one.
- FSM states:
  - IDLE: if pending!=0, go to WAIT_FRAME.
  - WAIT_FRAME: on frame_tick, pick the winner round-robin starting at (last_grant+1) mod 3, skipping index 3. Drive insn_key from the package table, key_pressed=1, grant=winner, and go to ISSUE in the same edge.
  - ISSUE: hold all outputs stable.
    - On insn_ack: clear pending[grant], set last_grant=grant, drive outputs to their idle values, go to IDLE.
    - If the timeout counter reaches ACK_TIMEOUT-1 without ack: same as ack, but pending[grant] stays set. Return to IDLE; the key is retried next frame.
- Rate: at most one issue per frame_tick. A frame_tick arriving in IDLE or ISSUE is ignored.
- Simultaneous events: a press on the same key in the cycle its ack arrives sets pending again (set wins over clear). Ack and timeout in the same cycle are treated as ack.
- If all pending bits are somehow cleared in WAIT_FRAME, return to IDLE without issuing.
- insn_ack while not in ISSUE is ignored.

Optional Feature:
KEY_AUTOREPEAT_EN
- Defined: a per-key frame counter runs while the key's debounced level is pressed. Every REPEAT_FRAMES frame_ticks it sets pending[k]; the counter clears on release. This gives continuous movement or fire while a key is held.
- Undefined: only press edges set pending. The counters are not built.

Decomposition:
- Package key_insn_pkg holds:
  - instruction constants KEY_INSN_RIGHT=32'h58000001, KEY_INSN_FIRE=32'h58000002, KEY_INSN_LEFT=32'h58000003, KEY_INSN_NONE=32'h0;
  - the FSM state enum (IDLE, WAIT_FRAME, ISSUE);
  - key index constants (0/1/2) and GRANT_NONE=2'd3.
- One sub-module, key_debounce (synchroniser + debouncer + press-edge pulse), instantiated three times.

Test Plan:
- Reset, no keys -> insn_key=0, key_pressed=0, grant=3, pending=0 for 100 cycles, including across frame_ticks.
- DEBOUNCE_CYCLES=4. Pull key_n[0] low and hold -> pending[0] set 6 cycles after the raw edge. Next frame_tick -> insn_key=32'h58000001, grant=0. insn_ack -> outputs idle the next cycle.
- Bounce key_n[1] with alternating 2-cycle pulses for 20 cycles, then hold low -> exactly one press detected and one FIRE (32'h58000002) issued.
- All three keys pressed together, ack each immediately -> issues on three successive frame_ticks in order 0 (RIGHT), 1 (FIRE), 2 (LEFT). Re-press all three -> order restarts at 0 after last_grant=2.
- ACK_TIMEOUT=8, never ack -> key_pressed drops after 8 cycles and pending stays 1. The next frame_tick re-issues the same word.
- Assert reset while in ISSUE -> key_pressed=0 and pending=0 the next cycle. With KEY_AUTOREPEAT_EN and REPEAT_FRAMES=2, hold LEFT -> a LEFT issue every 2 frames until release.
